lead_one_enc: RTL and testbench

Parametrised, pipelined priority encoder for the floating-point datapath. It locates the most-significant (or, optionally, least-significant) set bit of a WIDTH-bit word. It returns that bit's index, the leading/trailing zero count and an all-zero flag, through a two-stage valid/ready pipeline. It feeds the normalisation shifter after mantissa add/subtract and replaces the fixed 8-to-3 one-hot encoder where priority resolution, wider words and registered timing are needed.

---
 rtl/lead_one_enc_if.sv | 30 +++
 rtl/lead_one_enc.sv | 113 +++++++++++
 tb/tb_lead_one_enc.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lead_one_enc_if.sv
// Valid/ready bus for lead_one_enc: input word stream in, encoded result stream out.
//   in_valid/in_ready/in_data   : word to encode
//   out_valid/out_ready         : result handshake
//   out_idx/out_cnt/out_zero    : selected bit index, zero count, all-zero flag
interface lead_one_enc_if #(
  parameter int unsigned WIDTH = 32
);
  localparam int unsigned IDXW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [IDXW-1:0]  out_idx;
  logic [IDXW:0]    out_cnt;
  logic             out_zero;

  // Producer of words / consumer of results.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_idx, out_cnt, out_zero
  );

  // The encoder itself.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_idx, out_cnt, out_zero
  );
endinterface

// File: rtl/lead_one_enc.sv
// Two-stage pipelined priority encoder. Finds the highest (LSB_FIRST=0) or lowest
// (LSB_FIRST=1) set bit of a WIDTH-bit word and reports its index, the
// leading/trailing zero count and an all-zero flag.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : lead_one_enc_if slave (input word stream, result stream)
// Stage 1 resolves priority inside each 8-bit group; stage 2 picks the group.
module lead_one_enc #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          LSB_FIRST = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  lead_one_enc_if.slave  bus
);
  localparam int unsigned IDXW = $clog2(WIDTH);
  localparam int unsigned NGRP = WIDTH / 8;
  localparam int unsigned CNTW = IDXW + 1;

  logic                 s1_valid;
  logic [NGRP-1:0][2:0] s1_idx;
  logic [NGRP-1:0]      s1_nz;

  logic                 s1_adv;
  logic                 s2_adv;

  logic [NGRP-1:0][2:0] grp_idx_c;
  logic [NGRP-1:0]      grp_nz_c;
  logic [IDXW-1:0]      idx_c;
  logic [CNTW-1:0]      cnt_c;
  logic                 zero_c;

  // Handshake: a stage advances when it is empty or its consumer takes its content.
  assign s2_adv       = !bus.out_valid || bus.out_ready;
  assign s1_adv       = !s1_valid || s2_adv;
  assign bus.in_ready = s1_adv;

  // Per-group priority index; later loop iterations win, so the scan order sets priority.
  always_comb begin
    grp_idx_c = '0;
    grp_nz_c  = '0;
    for (int g = 0; g < NGRP; g++) begin
      if (LSB_FIRST) begin
        for (int b = 7; b >= 0; b--) begin
          if (bus.in_data[g*8 + b]) begin
            grp_idx_c[g] = 3'(b);
            grp_nz_c[g]  = 1'b1;
          end
        end
      end else begin
        for (int b = 0; b < 8; b++) begin
          if (bus.in_data[g*8 + b]) begin
            grp_idx_c[g] = 3'(b);
            grp_nz_c[g]  = 1'b1;
          end
        end
      end
    end
  end

  // Stage 1 registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      s1_nz    <= '0;
    end else if (s1_adv) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_idx <= grp_idx_c;
        s1_nz  <= grp_nz_c;
      end
    end
  end

  // Group selection and zero count; same last-wins scan as stage 1.
  always_comb begin
    idx_c  = '0;
    zero_c = ~|s1_nz;
    if (LSB_FIRST) begin
      for (int g = int'(NGRP) - 1; g >= 0; g--) begin
        if (s1_nz[g]) idx_c = IDXW'(g * 8) + IDXW'(s1_idx[g]);
      end
    end else begin
      for (int g = 0; g < NGRP; g++) begin
        if (s1_nz[g]) idx_c = IDXW'(g * 8) + IDXW'(s1_idx[g]);
      end
    end
    if (zero_c) begin
      cnt_c = CNTW'(WIDTH);
    end else if (LSB_FIRST) begin
      cnt_c = CNTW'(idx_c);
    end else begin
      cnt_c = CNTW'(WIDTH - 1) - CNTW'(idx_c);
    end
  end

  // Stage 2 (output) registers; held while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_idx   <= '0;
      bus.out_cnt   <= '0;
      bus.out_zero  <= 1'b0;
    end else if (s2_adv) begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.out_idx  <= idx_c;
        bus.out_cnt  <= cnt_c;
        bus.out_zero <= zero_c;
      end
    end
  end
endmodule

// File: tb/tb_lead_one_enc.sv
// Bench for lead_one_enc: three instances (32-bit leading, 32-bit trailing,
// 64-bit leading) share one stimulus stream; results are checked against a
// hand-computed vector table and a bit-serial reference model.
module tb_lead_one_enc;
  logic        clk;
  logic        rst_n;
  logic        vin;
  logic [63:0] vdata;
  logic        ordy;

  int ntot;
  int npass;
  int naccept;

  typedef struct packed {
    logic       zero;
    logic [6:0] cnt;
    logic [5:0] idx;
  } res_t;

  typedef struct {
    logic [63:0] d;
    int          li, lc;
    int          ti, tc;
    bit          z32;
    int          di, dc;
    bit          z64;
  } vec_t;

  res_t qa[$];
  res_t qb[$];
  res_t qc[$];
  bit   sa, sc;
  res_t ra_prev, rc_prev;

  lead_one_enc_if #(.WIDTH(32)) ifa ();
  lead_one_enc_if #(.WIDTH(32)) ifb ();
  lead_one_enc_if #(.WIDTH(64)) ifc ();

  assign ifa.in_valid  = vin;
  assign ifa.in_data   = vdata[31:0];
  assign ifa.out_ready = ordy;
  assign ifb.in_valid  = vin;
  assign ifb.in_data   = vdata[31:0];
  assign ifb.out_ready = ordy;
  assign ifc.in_valid  = vin;
  assign ifc.in_data   = vdata;
  assign ifc.out_ready = ordy;

  lead_one_enc #(.WIDTH(32), .LSB_FIRST(1'b0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  lead_one_enc #(.WIDTH(32), .LSB_FIRST(1'b1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  lead_one_enc #(.WIDTH(64), .LSB_FIRST(1'b0)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Bit-serial reference: scan every bit, last hit in scan order wins.
  function automatic res_t model(input logic [63:0] d, input int w, input bit lsb);
    res_t r;
    r.zero = 1'b1;
    r.idx  = '0;
    r.cnt  = 7'(w);
    if (lsb) begin
      for (int i = w - 1; i >= 0; i--)
        if (d[i]) begin r.idx = 6'(i); r.zero = 1'b0; end
    end else begin
      for (int i = 0; i < w; i++)
        if (d[i]) begin r.idx = 6'(i); r.zero = 1'b0; end
    end
    if (!r.zero) r.cnt = lsb ? 7'(r.idx) : 7'(w - 1 - int'(r.idx));
    return r;
  endfunction

  // One clock with scoreboard monitoring; inputs are set by the caller just before.
  task automatic step();
    res_t ra, rb, rc;
    #1;
    ra = '{zero: ifa.out_zero, cnt: 7'(ifa.out_cnt), idx: 6'(ifa.out_idx)};
    rb = '{zero: ifb.out_zero, cnt: 7'(ifb.out_cnt), idx: 6'(ifb.out_idx)};
    rc = '{zero: ifc.out_zero, cnt: 7'(ifc.out_cnt), idx: 6'(ifc.out_idx)};
    if (sa) chk("stall_hold_a", ra, ra_prev);
    if (sc) chk("stall_hold_c", rc, rc_prev);
    if (ifa.out_valid && ordy) begin
      if (qa.size() == 0) chk("spurious_a", ifa.out_valid, 0);
      else chk("stream_a", ra, qa.pop_front());
    end
    if (ifb.out_valid && ordy) begin
      if (qb.size() == 0) chk("spurious_b", ifb.out_valid, 0);
      else chk("stream_b", rb, qb.pop_front());
    end
    if (ifc.out_valid && ordy) begin
      if (qc.size() == 0) chk("spurious_c", ifc.out_valid, 0);
      else chk("stream_c", rc, qc.pop_front());
    end
    if (vin && ifa.in_ready) begin qa.push_back(model(vdata, 32, 1'b0)); naccept++; end
    if (vin && ifb.in_ready) qb.push_back(model(vdata, 32, 1'b1));
    if (vin && ifc.in_ready) qc.push_back(model(vdata, 64, 1'b0));
    sa = ifa.out_valid && !ordy;
    sc = ifc.out_valid && !ordy;
    ra_prev = ra;
    rc_prev = rc;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    vin  = 1'b0;
    ordy = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (qa.size() == 0 && qb.size() == 0 && qc.size() == 0 && !ifa.out_valid) break;
      step();
    end
    chk("drain_a", qa.size(), 0);
    chk("drain_b", qb.size(), 0);
    chk("drain_c", qc.size(), 0);
  endtask

  vec_t tv[9];

  initial begin
    ntot = 0; npass = 0; naccept = 0;
    sa = 1'b0; sc = 1'b0;
    ra_prev = '0; rc_prev = '0;

    //          data                      lz32      tz32     z32 lz64     z64
    tv[0] = '{64'h0000_0000_0001_0000, 16, 15, 16, 16, 1'b0, 16, 47, 1'b0};
    tv[1] = '{64'h0000_0000_8000_0001, 31,  0,  0,  0, 1'b0, 31, 32, 1'b0};
    tv[2] = '{64'h0000_0000_0000_0001,  0, 31,  0,  0, 1'b0,  0, 63, 1'b0};
    tv[3] = '{64'h0000_0000_0000_0000,  0, 32,  0, 32, 1'b1,  0, 64, 1'b1};
    tv[4] = '{64'h0000_0000_0001_0100, 16, 15,  8,  8, 1'b0, 16, 47, 1'b0};
    tv[5] = '{64'h0000_0000_8000_0000, 31,  0, 31, 31, 1'b0, 31, 32, 1'b0};
    tv[6] = '{64'h8000_0000_0000_00F0,  7, 24,  4,  4, 1'b0, 63,  0, 1'b0};
    tv[7] = '{64'h0000_0001_0F00_0000, 27,  4, 24, 24, 1'b0, 32, 31, 1'b0};
    tv[8] = '{64'hFFFF_0000_0000_0000,  0, 32,  0, 32, 1'b1, 63,  0, 1'b0};

    // Reset held with traffic offered.
    rst_n = 1'b0;
    vin   = 1'b1;
    vdata = '1;
    ordy  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid_a", ifa.out_valid, 0);
    chk("rst_idx_a", ifa.out_idx, 0);
    chk("rst_cnt_a", ifa.out_cnt, 0);
    chk("rst_zero_a", ifa.out_zero, 0);
    chk("rst_valid_c", ifc.out_valid, 0);
    chk("rst_inrdy_a", ifa.in_ready, 1);
    rst_n = 1'b1;
    vin   = 1'b0;
    #1;
    chk("rel_inrdy_a", ifa.in_ready, 1);
    @(posedge clk);
    #1;

    // Directed table: one word at a time, two-register latency.
    foreach (tv[i]) begin
      vin   = 1'b1;
      vdata = tv[i].d;
      ordy  = 1'b1;
      @(posedge clk);
      #1;
      vin = 1'b0;
      chk("lat1_valid_a", ifa.out_valid, 0);
      @(posedge clk);
      #1;
      chk("lat2_valid_a", ifa.out_valid, 1);
      chk("lat2_valid_b", ifb.out_valid, 1);
      chk("lat2_valid_c", ifc.out_valid, 1);
      chk("lz32_idx", ifa.out_idx, tv[i].li);
      chk("lz32_cnt", ifa.out_cnt, tv[i].lc);
      chk("lz32_zero", ifa.out_zero, tv[i].z32);
      chk("tz32_idx", ifb.out_idx, tv[i].ti);
      chk("tz32_cnt", ifb.out_cnt, tv[i].tc);
      chk("tz32_zero", ifb.out_zero, tv[i].z32);
      chk("lz64_idx", ifc.out_idx, tv[i].di);
      chk("lz64_cnt", ifc.out_cnt, tv[i].dc);
      chk("lz64_zero", ifc.out_zero, tv[i].z64);
      @(posedge clk);
      #1;
    end

    // Back-to-back random stream, no backpressure.
    naccept = 0;
    vin  = 1'b1;
    ordy = 1'b1;
    for (int k = 0; k < 100; k++) begin
      vdata = {$urandom, $urandom};
      if (k % 7 == 0) vdata = vdata >> $urandom_range(63, 20);
      step();
    end
    chk("b2b_accepts", naccept, 100);
    drain();

    // Backpressure: five stalled cycles while offering words.
    naccept = 0;
    vin  = 1'b1;
    ordy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      vdata = {$urandom, $urandom} >> k;
      step();
    end
    chk("bp_accepts", naccept, 2);
    chk("bp_inrdy_low", ifa.in_ready, 0);
    chk("bp_valid_held", ifa.out_valid, 1);
    ordy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      vdata = {$urandom, $urandom};
      step();
    end
    chk("bp_total_accepts", naccept, 8);
    drain();

    // Reset with both stages full.
    vin  = 1'b1;
    ordy = 1'b0;
    for (int k = 0; k < 2; k++) begin
      vdata = 64'h0000_0400_0000_0000 << k;
      step();
    end
    chk("mid_full_valid_c", ifc.out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid_c", ifc.out_valid, 0);
    chk("mid_rst_inrdy_c", ifc.in_ready, 1);
    qa.delete(); qb.delete(); qc.delete();
    sa = 1'b0; sc = 1'b0;
    vin = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ordy  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("post_rst_valid_c", ifc.out_valid, 0);
      step();
    end
    vin   = 1'b1;
    vdata = 64'h0020_0000_0000_0000;
    step();
    vin = 1'b0;
    step();
    chk("post_rst_new_valid_c", ifc.out_valid, 1);
    chk("post_rst_new_idx_c", ifc.out_idx, 53);
    chk("post_rst_new_cnt_c", ifc.out_cnt, 10);
    drain();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
